// File: rtl/ps2_paddle_scheduler_if.sv
// Bundle between the PS/2 receiver and the Pong paddle logic: scan-code byte
// stream in, per-player move strobes, held-key flags and move tick out.
interface ps2_paddle_scheduler_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic [3:0] keys_held;
  logic       move_tick;

  modport master (
    output received_data, received_data_en,
    input  p1_up, p1_down, p2_up, p2_down, keys_held, move_tick
  );

  modport slave (
    input  received_data, received_data_en,
    output p1_up, p1_down, p2_up, p2_down, keys_held, move_tick
  );
endinterface

// File: rtl/ps2_paddle_scheduler.sv
// PS/2 set-2 make/break parser with held-key tracking and rate-limited paddle strobes.
// Optional macro PS2_PREFIX_TIMEOUT_EN abandons a stale E0/F0 prefix after PREFIX_TIMEOUT idle cycles.
module ps2_paddle_scheduler #(
  parameter int MOVE_DIV       = 833333,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input logic                    CLOCK_50,
  input logic                    reset,
  ps2_paddle_scheduler_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_E0   = 2'd1;
  localparam logic [1:0] ST_F0   = 2'd2;
  localparam logic [1:0] ST_E0F0 = 2'd3;

  localparam int CNT_W = $clog2(MOVE_DIV);

  logic [1:0]       state, state_next;
  logic [3:0]       held, held_next;
  logic [1:0]       pref, pref_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             at_wrap;
  logic             byte_is_e0, byte_is_f0;
  logic             complete, is_ext, is_break;
  logic [3:0]       key_hit;
  logic             p1_go_up, p1_go_down, p2_go_up, p2_go_down;

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);
  logic [TO_W-1:0] prefix_cnt;
  logic            prefix_expired;

  assign prefix_expired = (state != ST_IDLE) && !bus.received_data_en &&
                          (prefix_cnt == TO_W'(PREFIX_TIMEOUT - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset || bus.received_data_en || state == ST_IDLE || prefix_expired)
      prefix_cnt <= '0;
    else
      prefix_cnt <= prefix_cnt + 1'b1;
  end
`endif

  assign byte_is_e0 = (bus.received_data == 8'hE0);
  assign byte_is_f0 = (bus.received_data == 8'hF0);
  assign is_ext     = (state == ST_E0) || (state == ST_E0F0);
  assign is_break   = (state == ST_F0) || (state == ST_E0F0);

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    if (bus.received_data_en) begin
      case (state)
        ST_IDLE: begin
          if (byte_is_e0)      state_next = ST_E0;
          else if (byte_is_f0) state_next = ST_F0;
          else                 complete   = 1'b1;
        end
        ST_E0: begin
          if (byte_is_f0) state_next = ST_E0F0;
          else if (!byte_is_e0) begin
            complete   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        // Break states swallow stray prefixes and wait for the actual code.
        default: begin
          if (!byte_is_e0 && !byte_is_f0) begin
            complete   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      endcase
    end
`ifdef PS2_PREFIX_TIMEOUT_EN
    else if (prefix_expired) begin
      state_next = ST_IDLE;
    end
`endif
  end

  // Keypad 0x75/0x72 without E0 are deliberately not mapped.
  always_comb begin
    key_hit = 4'b0000;
    if (!is_ext) begin
      case (bus.received_data)
        8'h1D:   key_hit = 4'b0001;
        8'h1B:   key_hit = 4'b0010;
        8'h44:   key_hit = 4'b0100;
        8'h42:   key_hit = 4'b1000;
        default: key_hit = 4'b0000;
      endcase
    end else begin
      case (bus.received_data)
        8'h75:   key_hit = 4'b0100;
        8'h72:   key_hit = 4'b1000;
        default: key_hit = 4'b0000;
      endcase
    end
  end

  // Preference only follows fresh presses so typematic repeats cannot flip it.
  always_comb begin
    held_next = held;
    pref_next = pref;
    if (complete) begin
      if (is_break) begin
        held_next = held & ~key_hit;
      end else begin
        held_next = held | key_hit;
        if (key_hit[0] && !held[0]) pref_next[0] = 1'b0;
        if (key_hit[1] && !held[1]) pref_next[0] = 1'b1;
        if (key_hit[2] && !held[2]) pref_next[1] = 1'b0;
        if (key_hit[3] && !held[3]) pref_next[1] = 1'b1;
      end
    end
  end

  assign at_wrap    = (tick_cnt == CNT_W'(MOVE_DIV - 1));
  assign p1_go_up   = held[0] && (!held[1] || !pref[0]);
  assign p1_go_down = held[1] && (!held[0] ||  pref[0]);
  assign p2_go_up   = held[2] && (!held[3] || !pref[1]);
  assign p2_go_down = held[3] && (!held[2] ||  pref[1]);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= ST_IDLE;
      held          <= 4'b0000;
      pref          <= 2'b00;
      tick_cnt      <= '0;
      bus.move_tick <= 1'b0;
      bus.p1_up     <= 1'b0;
      bus.p1_down   <= 1'b0;
      bus.p2_up     <= 1'b0;
      bus.p2_down   <= 1'b0;
    end else begin
      state         <= state_next;
      held          <= held_next;
      pref          <= pref_next;
      tick_cnt      <= at_wrap ? '0 : tick_cnt + 1'b1;
      bus.move_tick <= at_wrap;
      bus.p1_up     <= at_wrap && p1_go_up;
      bus.p1_down   <= at_wrap && p1_go_down;
      bus.p2_up     <= at_wrap && p2_go_up;
      bus.p2_down   <= at_wrap && p2_go_down;
    end
  end

  assign bus.keys_held = held;

endmodule

// File: tb/tb_ps2_paddle_scheduler.sv
// Self-checking bench for ps2_paddle_scheduler: directed scenarios with literal
// expectations plus randomized byte traffic checked every cycle against a key-state model.
module tb_ps2_paddle_scheduler;

  localparam int MOVE_DIV       = 8;
  localparam int PREFIX_TIMEOUT = 20;

  logic CLOCK_50;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic model_ok;

  ps2_paddle_scheduler_if bus ();

  ps2_paddle_scheduler #(
    .MOVE_DIV       (MOVE_DIV),
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Model view: which keys are down, who was pressed last, which prefixes are pending.
  typedef struct packed {
    logic [3:0]  held;
    logic [1:0]  pref;
    logic        ext;
    logic        brk;
    int unsigned n;
    int unsigned wait_c;
    logic        tick;
    logic [3:0]  strobes;
  } model_t;

  model_t m;

  function automatic int key_index(logic ext, logic [7:0] b);
    if (!ext && b == 8'h1D) return 0;
    if (!ext && b == 8'h1B) return 1;
    if (!ext && b == 8'h44) return 2;
    if (!ext && b == 8'h42) return 3;
    if (ext && b == 8'h75)  return 2;
    if (ext && b == 8'h72)  return 3;
    return -1;
  endfunction

  function automatic model_t model_step(model_t s, logic en, logic [7:0] d);
    model_t r;
    int     k;
    logic   up, dn;
    r = s;
    r.tick    = (s.n == MOVE_DIV - 1);
    r.strobes = 4'b0000;
    for (int p = 0; p < 2; p++) begin
      up = s.held[2*p];
      dn = s.held[2*p+1];
      if (r.tick) begin
        if (up && !dn)      r.strobes[2*p]   = 1'b1;
        else if (dn && !up) r.strobes[2*p+1] = 1'b1;
        else if (up && dn) begin
          if (s.pref[p]) r.strobes[2*p+1] = 1'b1;
          else           r.strobes[2*p]   = 1'b1;
        end
      end
    end
    r.n = (s.n + 1) % MOVE_DIV;
    if (en) begin
      r.wait_c = 0;
      if (d == 8'hE0) begin
        if (!s.brk) r.ext = 1'b1;
      end else if (d == 8'hF0) begin
        if (!s.brk) r.brk = 1'b1;
      end else begin
        k = key_index(s.ext, d);
        if (k >= 0) begin
          if (s.brk) r.held[k] = 1'b0;
          else begin
            if (!s.held[k]) r.pref[k/2] = k[0];
            r.held[k] = 1'b1;
          end
        end
        r.ext = 1'b0;
        r.brk = 1'b0;
      end
    end else if (s.ext || s.brk) begin
`ifdef PS2_PREFIX_TIMEOUT_EN
      r.wait_c = s.wait_c + 1;
      if (r.wait_c == PREFIX_TIMEOUT) begin
        r.ext    = 1'b0;
        r.brk    = 1'b0;
        r.wait_c = 0;
      end
`endif
    end
    return r;
  endfunction

  always @(posedge CLOCK_50) begin
    if (reset) begin
      m        <= '0;
      model_ok <= 1'b1;
    end else begin
      m <= model_step(m, bus.received_data_en, bus.received_data);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (model_ok === 1'b1) begin
      checkOutput("model move_tick", {7'd0, bus.move_tick}, {7'd0, m.tick});
      checkOutput("model strobes", {4'd0, bus.p2_down, bus.p2_up, bus.p1_down, bus.p1_up},
                  {4'd0, m.strobes});
      checkOutput("model keys_held", {4'd0, bus.keys_held}, {4'd0, m.held});
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge CLOCK_50);
    bus.received_data_en = 1'b0;
  endtask

  task automatic countWindow(input int cycles, output int ticks, output int p1u, output int p1d,
                             output int p2u, output int p2d);
    ticks = 0; p1u = 0; p1d = 0; p2u = 0; p2d = 0;
    repeat (cycles) begin
      @(negedge CLOCK_50);
      ticks += int'(bus.move_tick);
      p1u   += int'(bus.p1_up);
      p1d   += int'(bus.p1_down);
      p2u   += int'(bus.p2_up);
      p2d   += int'(bus.p2_down);
    end
  endtask

  task automatic waitTick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * MOVE_DIV; i++) begin
      @(negedge CLOCK_50);
      if (bus.move_tick) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("move_tick timeout", 8'd0, 8'd1);
  endtask

  int t, u1, d1, u2, d2;

  initial begin
    tests_run            = 0;
    tests_failed         = 0;
    model_ok             = 1'b0;
    reset                = 1'b1;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("reset keys_held", {4'd0, bus.keys_held}, 8'h00);
    reset = 1'b0;

    // Idle: ticks every MOVE_DIV cycles, no strobes.
    countWindow(32, t, u1, d1, u2, d2);
    checkOutput("idle tick count", 8'(t), 8'd4);
    checkOutput("idle strobe count", 8'(u1 + d1 + u2 + d2), 8'd0);

    // W held then released.
    applyStimulus(8'h1D);
    checkOutput("W make held", {4'd0, bus.keys_held}, 8'h01);
    countWindow(16, t, u1, d1, u2, d2);
    checkOutput("W held p1_up count", 8'(u1), 8'd2);
    applyStimulus(8'hF0);
    applyStimulus(8'h1D);
    checkOutput("W break held", {4'd0, bus.keys_held}, 8'h00);
    countWindow(16, t, u1, d1, u2, d2);
    checkOutput("W released p1_up count", 8'(u1), 8'd0);

    // W+S: last pressed wins, repeat make keeps preference.
    applyStimulus(8'h1D);
    applyStimulus(8'h1B);
    checkOutput("W+S held", {4'd0, bus.keys_held}, 8'h03);
    countWindow(16, t, u1, d1, u2, d2);
    checkOutput("W+S p1_down count", 8'(d1), 8'd2);
    checkOutput("W+S p1_up count", 8'(u1), 8'd0);
    applyStimulus(8'h1D);
    countWindow(16, t, u1, d1, u2, d2);
    checkOutput("W repeat p1_down count", 8'(d1), 8'd2);
    applyStimulus(8'hF0);
    applyStimulus(8'h1B);
    countWindow(16, t, u1, d1, u2, d2);
    checkOutput("S released p1_up count", 8'(u1), 8'd2);
    checkOutput("S released p1_down count", 8'(d1), 8'd0);
    applyStimulus(8'hF0);
    applyStimulus(8'h1D);

    // Extended arrows share the p2 flags with O/K.
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    checkOutput("E0 75 held", {4'd0, bus.keys_held}, 8'h04);
    applyStimulus(8'h75);
    checkOutput("keypad 75 ignored", {4'd0, bus.keys_held}, 8'h04);
    countWindow(16, t, u1, d1, u2, d2);
    checkOutput("arrow p2_up count", 8'(u2), 8'd2);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkOutput("E0 F0 75 cleared", {4'd0, bus.keys_held}, 8'h00);
    applyStimulus(8'h44);
    checkOutput("O make held", {4'd0, bus.keys_held}, 8'h04);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkOutput("arrow break clears O", {4'd0, bus.keys_held}, 8'h00);

    // Byte landing in the counter==MOVE_DIV-1 cycle only affects the next tick.
    waitTick();
    repeat (MOVE_DIV - 1) @(negedge CLOCK_50);
    applyStimulus(8'h1B);
    checkOutput("late byte tick", {7'd0, bus.move_tick}, 8'd1);
    checkOutput("late byte no p1_down", {7'd0, bus.p1_down}, 8'd0);
    repeat (MOVE_DIV) @(negedge CLOCK_50);
    checkOutput("next tick", {7'd0, bus.move_tick}, 8'd1);
    checkOutput("next tick p1_down", {7'd0, bus.p1_down}, 8'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1B);

    // Stale break prefix followed by W after a long gap.
    applyStimulus(8'hF0);
    repeat (25) @(negedge CLOCK_50);
    applyStimulus(8'h1D);
`ifdef PS2_PREFIX_TIMEOUT_EN
    checkOutput("prefix timeout make", {4'd0, bus.keys_held}, 8'h01);
    applyStimulus(8'hF0);
    applyStimulus(8'h1D);
`else
    checkOutput("prefix kept break", {4'd0, bus.keys_held}, 8'h00);
`endif

    // Reset in the middle of a break sequence.
    applyStimulus(8'h44);
    applyStimulus(8'hF0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("mid reset outputs",
                {bus.move_tick, bus.p2_down, bus.p2_up, bus.p1_down, bus.p1_up, bus.keys_held[2:0]},
                8'h00);
    reset = 1'b0;
    applyStimulus(8'h1D);
    checkOutput("make after mid reset", {4'd0, bus.keys_held}, 8'h01);

    // Random traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [7:0] b;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: b = 8'h1D;
        1: b = 8'h1B;
        2: b = 8'h44;
        3: b = 8'h42;
        4: b = 8'h75;
        5: b = 8'h72;
        6: b = 8'hE0;
        7: b = 8'hF0;
        8: b = 8'($urandom_range(0, 255));
        default: b = 8'hF0;
      endcase
      reset                = ($urandom_range(0, 999) < 3);
      bus.received_data    = b;
      bus.received_data_en = ($urandom_range(0, 2) == 0);
      @(negedge CLOCK_50);
    end
    reset                = 1'b0;
    bus.received_data_en = 1'b0;
    repeat (4) @(negedge CLOCK_50);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_paddle_scheduler.md
Name: ps2_paddle_scheduler

Overview:
Sits between the PS/2 controller's received-byte stream and the Pong paddle logic. It parses PS/2 set-2 make/break sequences, including the F0 break prefix and E0 extended prefix, and tracks the held state of the six paddle keys. It then issues rate-limited, conflict-resolved one-cycle move strobes per player on a fixed move tick. It replaces per-byte key mapping with true press/release tracking, so paddles move while a key is held and stop on release.

Parameters:
MOVE_DIV, 833333, CLOCK_50 cycles per move tick (60 Hz at 50 MHz); legal range >= 2
PREFIX_TIMEOUT, 50000, cycles a prefix state may wait for its next byte (used only with the optional feature)

Ports:
CLOCK_50  input  1  system clock
reset  input  1  synchronous, active-high reset
received_data  input  8  scan-code byte from the PS/2 controller
received_data_en  input  1  one-cycle strobe; received_data valid this cycle
p1_up  output  1  one-cycle move-up strobe, player 1
p1_down  output  1  one-cycle move-down strobe, player 1
p2_up  output  1  one-cycle move-up strobe, player 2
p2_down  output  1  one-cycle move-down strobe, player 2
keys_held  output  4  {p2_down, p2_up, p1_down, p1_up} held flags
move_tick  output  1  one-cycle strobe marking each move tick

Behaviour:
- Reset is synchronous and active-high, sampled on posedge CLOCK_50. It dominates all other inputs.
- Reset values: all outputs 0; parser in IDLE; tick counter 0; preference bits 0 (UP).
- Parser FSM states: IDLE, E0, F0, E0F0. It advances only on cycles where received_data_en is 1.
  - IDLE: 0xE0 -> E0; 0xF0 -> F0; any other byte is a make code -> IDLE.
  - E0: 0xF0 -> E0F0; 0xE0 -> stay E0; other byte is an extended make -> IDLE.
  - F0: byte is a break code -> IDLE (0xE0/0xF0 here are ignored; stay F0).
  - E0F0: byte is an extended break -> IDLE (0xE0/0xF0 here are ignored; stay E0F0).
- Key map:
  - Non-extended: 0x1D=W -> p1_up; 0x1B=S -> p1_down; 0x44=O -> p2_up; 0x42=K -> p2_down.
  - Extended (E0-prefixed): 0x75 -> p2_up; 0x72 -> p2_down.
  - Non-extended 0x75/0x72 (keypad) are ignored. Unmapped codes change no state but still return the FSM to IDLE.
- Held flag: make sets the flag, break clears it.
  - keys_held updates the cycle after the completing byte's strobe (1-cycle latency).
  - O and Up Arrow share the p2_up flag, and K and Down Arrow share p2_down; a break of either clears the flag.
- Per-player preference bit (last-pressed wins):
  - Updated only on a 0->1 transition of up or down.
  - Typematic repeat makes of an already-held key do not change it.
- Direction resolution per player, from held flags:
  - up only -> UP; down only -> DOWN.
  - both held -> preference bit.
  - neither held -> none.
- Tick counter: counts 0..MOVE_DIV-1 and wraps to 0. move_tick is high for exactly the one cycle after the counter equals MOVE_DIV-1.
- Move strobes: registered, high in the same cycle as move_tick, for at most one direction per player.
  - Direction is evaluated from the held flags and preference as they stood in the counter==MOVE_DIV-1 cycle.
  - A byte arriving in that same cycle affects the next tick only.
- Both players are independent; p1 and p2 strobes may assert in the same cycle.
- Reset mid-sequence (e.g. in F0): FSM returns to IDLE, held flags clear, and no strobes are issued in the reset cycle.

Optional Feature:
PS2_PREFIX_TIMEOUT_EN
- Defined:
  - A counter runs while the FSM is in E0, F0 or E0F0 and restarts on every received byte.
  - On reaching PREFIX_TIMEOUT cycles with no byte, the FSM returns to IDLE and the pending prefix is discarded.
  - Held flags are unchanged.
- Undefined: no timeout logic; the FSM waits in a prefix state indefinitely.

Test Plan:
All scenarios use MOVE_DIV=8 unless stated.
1. Reset, then idle 32 cycles -> move_tick pulses every 8 cycles; p1/p2 strobes stay 0; keys_held=0000.
2. Byte 0x1D, wait 16 cycles, then bytes 0xF0,0x1D -> keys_held[0]=1 one cycle after the 0x1D strobe; p1_up on each move_tick while held; keys_held[0]=0 after the break; no further p1_up.
3. Make 0x1D, then make 0x1B (both held) -> p1_down on ticks; break 0x1B -> p1_up resumes on the next tick; a repeated make 0x1D while held leaves the preference unchanged.
4. Bytes 0xE0,0x75 -> p2_up set; bytes 0x75 alone -> no change; 0xE0,0xF0,0x75 -> p2_up cleared; 0x44 make followed by 0xE0,0xF0,0x75 -> p2_up cleared.
5. Byte strobe completing 0x1B in the counter==7 cycle -> no p1_down on that tick; p1_down on the following tick.
6. With PS2_PREFIX_TIMEOUT_EN and PREFIX_TIMEOUT=20: byte 0xF0, idle 25 cycles, byte 0x1D -> treated as a make (keys_held[0]=1). Without the macro the same stimulus is a break (keys_held[0] stays 0).
